// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_pkg
// Purpose : Shared UART definitions: TX FSM state encoding, the baud-divisor
//           formula (identical to the receiver side) and a frame-length helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Clocks per bit; must stay identical to the receiver's divisor.
  function automatic int unsigned baud_div(input int unsigned clk_frq,
                                           input int unsigned baud);
    return clk_frq / baud;
  endfunction

  // Clocks per complete frame: start + data + optional parity + stop bits.
  function automatic int unsigned frame_clks(input int unsigned div,
                                             input int unsigned parity_en,
                                             input int unsigned stop_bits);
    return (1 + DATA_BITS + parity_en + stop_bits) * div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_sync_fifo
// Purpose : Single-clock FIFO. Full/empty are derived from an occupancy count,
//           pointers wrap naturally modulo DEPTH (power of 2).
// Ports   : Sys_clk, Rst_n (async, active-low)
//           push/wr_data  - write request, ignored when full
//           pop/rd_data   - read request, ignored when empty; rd_data shows
//                           the head entry combinationally
//           full, empty, level - status from the registered count
// Rev     : 1.0  initial release
// ============================================================================
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     Sys_clk,
  input  logic                     Rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LEVEL_FULL);
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only ever read after being written.
  always_ff @(posedge Sys_clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Purpose : UART transmitter (8N1 default, optional parity, 1 or 2 stop bits)
//           with an input FIFO. Serialises LSB first onto an idle-high line.
// Ports   : Sys_clk, Rst_n (async, active-low)
//           tx_data/tx_valid/tx_ready - byte write handshake into the FIFO
//           data_out   - registered serial line
//           tx_busy    - frame in progress or FIFO not empty
//           tx_done    - one-cycle pulse on the last clock of the last stop bit
//           fifo_level - FIFO occupancy
// Rev     : 1.0  initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int Sys_clk_frq = 50_000_000,
  parameter int baud_frq    = 115200,
  parameter int div_cnt_max = int'(baud_div(Sys_clk_frq, baud_frq)),
  parameter int cnt_width   = $clog2(div_cnt_max),
  parameter int FIFO_DEPTH  = 16,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                         Sys_clk,
  input  logic                         Rst_n,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         data_out,
  output logic                         tx_busy,
  output logic                         tx_done,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam logic [cnt_width-1:0] DIV_LAST  = cnt_width'(div_cnt_max - 1);
  localparam logic [2:0]           STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic                 ODD_SEED  = (PARITY_ODD != 0);

  tx_state_t            state;
  tx_state_t            next_state;
  logic [cnt_width-1:0] div_cnt;
  logic [2:0]           bit_cnt;
  logic [7:0]           shreg;
  logic                 parity_bit;
  logic                 baud_tick;
  logic                 fifo_pop;
  logic                 frame_end;
  logic [7:0]           fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .Sys_clk (Sys_clk),
    .Rst_n   (Rst_n),
    .push    (tx_valid),
    .wr_data (tx_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign tx_ready  = !fifo_full;
  assign tx_busy   = (state != ST_IDLE) || !fifo_empty;
  assign baud_tick = (div_cnt == DIV_LAST);

  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    frame_end  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) next_state = ST_DATA;
      end
      ST_DATA: begin
        if (baud_tick && bit_cnt == 3'd7)
          next_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (baud_tick) next_state = ST_STOP;
      end
      ST_STOP: begin
        if (baud_tick && bit_cnt == STOP_LAST) begin
          frame_end = 1'b1;
          // Chain straight into the next frame when data is waiting.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            next_state = ST_START;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Baud counter: held at zero in IDLE so every frame starts on a fresh bit.
  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n)                div_cnt <= '0;
    else if (state == ST_IDLE) div_cnt <= '0;
    else if (baud_tick)        div_cnt <= '0;
    else                       div_cnt <= div_cnt + 1'b1;
  end

  // Bit counter restarts on every state change; counts data bits and stop bits.
  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n)                    bit_cnt <= '0;
    else if (next_state != state)  bit_cnt <= '0;
    else if (baud_tick)            bit_cnt <= bit_cnt + 1'b1;
  end

  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      shreg      <= '0;
      parity_bit <= 1'b0;
    end else if (fifo_pop) begin
      shreg      <= fifo_rd_data;
      parity_bit <= (^fifo_rd_data) ^ ODD_SEED;
    end else if (state == ST_DATA && baud_tick) begin
      shreg      <= {1'b0, shreg[7:1]};
    end
  end

  // Line and done are registered from the current state, so the line lags
  // the FSM by one clock and tx_done lines up with the final stop clock.
  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_out <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= frame_end;
      unique case (state)
        ST_IDLE:   data_out <= 1'b1;
        ST_START:  data_out <= 1'b0;
        ST_DATA:   data_out <= shreg[0];
        ST_PARITY: data_out <= parity_bit;
        ST_STOP:   data_out <= 1'b1;
        default:   data_out <= 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_fifo
// Purpose : Self-checking bench for uart_tx_fifo. Three instances share the
//           write inputs: 8N1, 8E1 and 8O2. A line decoder compares frames on
//           the 8N1 instance against a queue of accepted bytes.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DIV     = 8;
  localparam int CLK_FRQ = 50_000_000;
  localparam int BAUD    = CLK_FRQ / DIV;
  localparam int DEPTH   = 16;

  logic       Sys_clk  = 1'b0;
  logic       Rst_n    = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;

  logic [2:0] line, done, ready, busy;
  logic [4:0] level_a, level_b, level_c;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  bit         mon_en   = 1'b0;
  bit         saw_full = 1'b0;

  typedef struct { logic [7:0] data; logic par_even; logic par_odd; } vec_t;
  vec_t        vecs [6];
  logic [11:0] cb [3];
  int          cd [3];
  int          cn [3];

  logic [9:0] m_bits;
  int         m_done_at, m_n_done;

  always #5 Sys_clk = ~Sys_clk;
  always @(posedge Sys_clk) cyc <= cyc + 1;

  uart_tx_fifo #(.Sys_clk_frq(CLK_FRQ), .baud_frq(BAUD), .FIFO_DEPTH(DEPTH),
                 .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut (
    .Sys_clk(Sys_clk), .Rst_n(Rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready[0]), .data_out(line[0]), .tx_busy(busy[0]),
    .tx_done(done[0]), .fifo_level(level_a));

  uart_tx_fifo #(.Sys_clk_frq(CLK_FRQ), .baud_frq(BAUD), .FIFO_DEPTH(DEPTH),
                 .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .Sys_clk(Sys_clk), .Rst_n(Rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready[1]), .data_out(line[1]), .tx_busy(busy[1]),
    .tx_done(done[1]), .fifo_level(level_b));

  uart_tx_fifo #(.Sys_clk_frq(CLK_FRQ), .baud_frq(BAUD), .FIFO_DEPTH(DEPTH),
                 .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_odd2 (
    .Sys_clk(Sys_clk), .Rst_n(Rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready[2]), .data_out(line[2]), .tx_busy(busy[2]),
    .tx_done(done[2]), .fifo_level(level_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Sys_clk);
  endtask

  task automatic do_reset();
    @(negedge Sys_clk);
    Rst_n    = 1'b0;
    tx_valid = 1'b0;
    tick(2);
    exp_q.delete();
    start_q.delete();
    Rst_n = 1'b1;
    tick(1);
  endtask

  // Holds the byte on the bus until the 8N1 instance accepts it; leaves
  // tx_valid high so consecutive calls form a burst.
  task automatic push(input logic [7:0] b);
    int guard = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!ready[0] && guard < 40 * DIV) begin
      if (!saw_full) begin
        saw_full = 1'b1;
        check("level_when_not_ready", level_a, DEPTH);
      end
      @(negedge Sys_clk);
      guard++;
    end
    if (!ready[0]) check("push_accept_timeout", ready[0], 1);
    else begin
      @(negedge Sys_clk);
      if (mon_en) exp_q.push_back(b);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy[0] && g < 10000) begin
      @(negedge Sys_clk);
      g++;
    end
    check("idle_reached", busy[0], 0);
    tick(3);
    check("all_bytes_sent", exp_q.size(), 0);
  endtask

  task automatic capture(input int k, input int nbits, output logic [11:0] bits,
                         output int done_at, output int n_done);
    int g = 0;
    bits    = '1;
    done_at = -1;
    n_done  = 0;
    @(negedge Sys_clk);
    while (line[k] !== 1'b0 && g < 20) begin
      @(negedge Sys_clk);
      g++;
    end
    if (line[k] !== 1'b0) return;
    for (int off = 0; off < (nbits + 1) * DIV; off++) begin
      if (off > 0) @(negedge Sys_clk);
      if (off % DIV == DIV / 2 && off / DIV < nbits) bits[off / DIV] = line[k];
      if (done[k]) begin
        n_done++;
        done_at = off;
      end
    end
  endtask

  // Line decoder for the 8N1 instance: samples each bit mid-way and checks
  // the decoded byte and tx_done position against the model queue.
  initial begin : monitor
    forever begin
      @(negedge Sys_clk);
      if (mon_en && Rst_n && line[0] == 1'b0) begin
        start_q.push_back(cyc);
        m_bits = '1; m_done_at = -1; m_n_done = 0;
        for (int off = 0; off < 10 * DIV; off++) begin
          if (off > 0) @(negedge Sys_clk);
          if (off % DIV == DIV / 2) m_bits[off / DIV] = line[0];
          if (done[0]) begin
            m_n_done++;
            m_done_at = off;
          end
        end
        check("frame_start_bit", m_bits[0], 0);
        check("frame_stop_bit", m_bits[9], 1);
        check("done_pulses_per_frame", m_n_done, 1);
        check("done_position", m_done_at, 10 * DIV - 1);
        if (exp_q.size() == 0) check("queued_byte_count", exp_q.size(), 1);
        else                   check("rx_byte", m_bits[8:1], exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    n_fail++;
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n_low, n_dn;
    vecs[0] = '{8'h07, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 1'b0, 1'b1};
    vecs[3] = '{8'h81, 1'b0, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 1'b0};
    vecs[5] = '{8'h6B, 1'b1, 1'b0};

    // Reset values
    @(negedge Sys_clk);
    check("rst_data_out", line[0], 1);
    check("rst_tx_ready", ready[0], 1);
    check("rst_tx_busy", busy[0], 0);
    check("rst_tx_done", done[0], 0);
    check("rst_fifo_level", level_a, 0);
    check("rst_line_parity", {line[2], line[1]}, 2'b11);
    Rst_n = 1'b1;
    tick(2);

    // Single byte: latency to start bit and full frame via decoder
    mon_en   = 1'b1;
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    exp_q.push_back(8'h55);
    tick(1);
    tx_valid = 1'b0;
    check("lat_line_n1", line[0], 1);
    check("lat_busy_n1", busy[0], 1);
    check("lat_level_n1", level_a, 1);
    tick(1);
    check("lat_line_n2", line[0], 1);
    check("lat_level_n2", level_a, 0);
    tick(1);
    check("lat_line_fall", line[0], 0);
    wait_idle();

    // Back-to-back frames without idle gap
    do_reset();
    push(8'hA3); push(8'h0F); push(8'hFF);
    tx_valid = 1'b0;
    wait_idle();
    check("b2b_frame_count", start_q.size(), 3);
    if (start_q.size() == 3) begin
      check("b2b_gap_1", start_q[1] - start_q[0], 10 * DIV);
      check("b2b_gap_2", start_q[2] - start_q[1], 10 * DIV);
    end

    // Overfill: ready must drop at level 16, all bytes still sent in order
    do_reset();
    saw_full = 1'b0;
    for (int i = 0; i < 18; i++) push(8'(i * 13 + 7));
    tx_valid = 1'b0;
    check("ready_dropped_when_full", saw_full, 1);
    wait_idle();

    // Parity / stop-bit table across the three instances
    mon_en = 1'b0;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      fork
        capture(0, 10, cb[0], cd[0], cn[0]);
        capture(1, 11, cb[1], cd[1], cn[1]);
        capture(2, 12, cb[2], cd[2], cn[2]);
        begin push(vecs[r].data); tx_valid = 1'b0; end
      join
      check("tbl_8n1_bits", cb[0][9:0], {1'b1, vecs[r].data, 1'b0});
      check("tbl_8e1_bits", cb[1][10:0], {1'b1, vecs[r].par_even, vecs[r].data, 1'b0});
      check("tbl_8o2_bits", cb[2], {2'b11, vecs[r].par_odd, vecs[r].data, 1'b0});
      check("tbl_8n1_done", cd[0], 10 * DIV - 1);
      check("tbl_8e1_done", cd[1], 11 * DIV - 1);
      check("tbl_8o2_done", cd[2], 12 * DIV - 1);
      check("tbl_done_counts", {cn[0][3:0], cn[1][3:0], cn[2][3:0]}, 12'h111);
      tick(4);
    end

    // Reset in the middle of the data phase with bytes queued
    do_reset();
    push(8'h81); push(8'h11); push(8'h22); push(8'h33);
    tx_valid = 1'b0;
    begin
      int g = 0;
      while (line[0] !== 1'b0 && g < 20) begin
        @(negedge Sys_clk);
        g++;
      end
    end
    tick(3 * DIV);
    check("queued_before_reset", level_a, 3);
    Rst_n = 1'b0;
    #1;
    check("midrst_data_out", line[0], 1);
    check("midrst_level", level_a, 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_ready", ready[0], 1);
    tick(2);
    Rst_n = 1'b1;
    n_low = 0;
    n_dn  = 0;
    for (int i = 0; i < 12 * DIV; i++) begin
      @(negedge Sys_clk);
      if (line[0] == 1'b0) n_low++;
      if (done[0]) n_dn++;
    end
    check("post_rst_line_low_cycles", n_low, 0);
    check("post_rst_done_pulses", n_dn, 0);

    // Randomised traffic against the byte-queue model
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      push(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        tx_valid = 1'b0;
        tick($urandom_range(1, 120));
      end
    end
    tx_valid = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
